// File: rtl/time_trig_pkg.sv
// Shared definitions for the time trigger queue: time width, FSM state
// encoding and the wrap-safe "is this time due" helper.
package time_trig_pkg;

  localparam int unsigned TIME_W = 32;

  // IDLE: no head entry. ARMED: head is compared against master_time every
  // cycle. POP: the head just fired (or was dropped) and is being replaced.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POP   = 2'd2
  } trig_state_e;

  // An entry is due once master_time has reached or passed its time. The
  // difference is taken modulo 2^32 and read as signed, so a time that lies
  // up to 2^31-1 ticks ahead stays "future" across wrap-around and across a
  // backwards jump of master_time.
  function automatic logic time_due(input logic [TIME_W-1:0] now,
                                    input logic [TIME_W-1:0] t);
    logic [TIME_W-1:0] diff;
    diff = now - t;
    return ~diff[TIME_W-1];
  endfunction

endpackage

// File: rtl/trig_fifo.sv
// Synchronous FIFO holding queued {time, tag} entries behind the head
// register. Depth need not be a power of two, so pointers wrap explicitly.
// The read port is first-word fall-through: data_o shows the oldest entry
// whenever the FIFO is not empty, so it can be loaded in the pop cycle.
module trig_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 7,
  parameter int unsigned LVL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A flush wins over any concurrent push or pop.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/time_trigger_queue.sv
// Time trigger queue: holds absolute trigger times with tags in strict FIFO
// order and strobes trig_o (or late_o) when master_time reaches the head.
// Optional build macro TIME_TRIG_LATE_DETECT_EN: when defined, entries more
// than LATE_THRESH ticks past due are reported on late_o instead of trig_o;
// when undefined, late_o is tied low and every due entry fires on trig_o.
//
// Producer handshake: an entry is taken on a rising clk edge where
// wr_valid & wr_ready are both high and clear is low. wr_ready depends only
// on registered occupancy (count < DEPTH), never on a same-cycle pop, and
// the producer must hold wr_time/wr_tag stable while wr_valid is high.
import time_trig_pkg::*;

module time_trigger_queue #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TAG_W       = 8,
  parameter int unsigned LATE_THRESH = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [TIME_W-1:0]        master_time,
  input  logic                     clear,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [TIME_W-1:0]        wr_time,
  input  logic [TAG_W-1:0]         wr_tag,
  output logic                     trig_o,
  output logic [TAG_W-1:0]         trig_tag,
  output logic                     late_o,
  output logic [$clog2(DEPTH):0]   count,
  output trig_state_e              dbg_state_o
);

  localparam int unsigned FIFO_D = DEPTH - 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W  = TIME_W + TAG_W;

  trig_state_e       state_q, state_d;
  logic              head_valid_q, head_valid_d;
  logic [TIME_W-1:0] head_time_q, head_time_d;
  logic [TAG_W-1:0]  head_tag_q, head_tag_d;
  logic              trig_q, trig_d;
  logic              late_q, late_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic [ENT_W-1:0]  fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_level;

  logic              push_acc;
  logic [TIME_W-1:0] diff;
  logic              due;
  logic              late_hit;

  assign count       = fifo_level + {{(CNT_W-1){1'b0}}, head_valid_q};
  assign wr_ready    = (count < CNT_W'(DEPTH));
  assign push_acc    = wr_valid & wr_ready & ~clear;
  assign trig_o      = trig_q;
  assign late_o      = late_q;
  assign trig_tag    = tag_q;
  assign dbg_state_o = state_q;

  assign diff = master_time - head_time_q;
  assign due  = time_due(master_time, head_time_q);

`ifdef TIME_TRIG_LATE_DETECT_EN
  assign late_hit = due & (diff > TIME_W'(LATE_THRESH));
`else
  logic unused_late;
  assign late_hit    = 1'b0;
  assign unused_late = (diff > TIME_W'(LATE_THRESH));
`endif

  trig_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_D),
    .LVL_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (clear),
    .data_i  ({wr_time, wr_tag}),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Next-state, head load and strobe decisions. Pushes go straight into the
  // head only when nothing is queued ahead of them; otherwise into the FIFO.
  always_comb begin
    state_d      = state_q;
    head_valid_d = head_valid_q;
    head_time_d  = head_time_q;
    head_tag_d   = head_tag_q;
    trig_d       = 1'b0;
    late_d       = 1'b0;
    tag_d        = tag_q;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    if (clear) begin
      state_d      = IDLE;
      head_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop                  = 1'b1;
            fifo_push                 = push_acc & ~fifo_full;
            {head_time_d, head_tag_d} = fifo_dout;
            head_valid_d              = 1'b1;
            state_d                   = ARMED;
          end else if (push_acc) begin
            head_time_d  = wr_time;
            head_tag_d   = wr_tag;
            head_valid_d = 1'b1;
            state_d      = ARMED;
          end
        end
        ARMED: begin
          fifo_push = push_acc & ~fifo_full;
          if (due) begin
            trig_d  = ~late_hit;
            late_d  = late_hit;
            tag_d   = head_tag_q;
            state_d = POP;
          end
        end
        POP: begin
          fifo_push = push_acc & ~fifo_full;
          if (!fifo_empty) begin
            fifo_pop                  = 1'b1;
            {head_time_d, head_tag_d} = fifo_dout;
            head_valid_d              = 1'b1;
            state_d                   = ARMED;
          end else begin
            head_valid_d = 1'b0;
            state_d      = IDLE;
          end
        end
        default: begin
          head_valid_d = 1'b0;
          state_d      = IDLE;
        end
      endcase
    end
  end

  // State, head entry and registered output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      head_valid_q <= 1'b0;
      head_time_q  <= '0;
      head_tag_q   <= '0;
      trig_q       <= 1'b0;
      late_q       <= 1'b0;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      head_valid_q <= head_valid_d;
      head_time_q  <= head_time_d;
      head_tag_q   <= head_tag_d;
      trig_q       <= trig_d;
      late_q       <= late_d;
      tag_q        <= tag_d;
    end
  end

endmodule

// File: doc/time_trigger_queue.md
Name: time_trigger_queue

Overview:
- Sits directly downstream of the time-sync block and consumes its 32-bit master_time.
- Holds a small queue of absolute trigger times, each with a tag, written by a producer through a valid/ready interface.
- Emits a one-cycle strobe with the tag when master_time reaches the head entry's time.
- Uses wrap-safe signed comparison, so the master_time jumps to 0 on PPS sync and 32-bit wrap-around are both handled.

Parameters:
- DEPTH, 8: queue entries; must be a power of 2, ≥2.
- TAG_W, 8: width of the user tag carried with each trigger.
- LATE_THRESH, 1000: ticks past the due time beyond which an entry counts as late.

Ports:
- clk  in  1  sys clock, same domain as master_time.
- rst_n  in  1  reset; asynchronous, active-low.
- master_time  in  32  free-running time from the time-sync block.
- clear  in  1  synchronous flush of queue and head.
- wr_valid  in  1  push request.
- wr_ready  out  1  queue can accept a push.
- wr_time  in  32  absolute trigger time.
- wr_tag  in  TAG_W  tag for the entry.
- trig_o  out  1  one-cycle fire strobe.
- trig_tag  out  TAG_W  tag of the fired or late entry; valid while trig_o or late_o is high.
- late_o  out  1  one-cycle strobe: entry discarded as late.
- count  out  $clog2(DEPTH)+1  entries held (FIFO plus head).

Behaviour:
- Reset (rst_n low, async):
  - Queue empty, FSM in IDLE.
  - trig_o=0, late_o=0, trig_tag=0, count=0, wr_ready=1.
- Push:
  - Accepted on a cycle where wr_valid & wr_ready.
  - wr_ready = (count < DEPTH). It is not combinationally dependent on a same-cycle pop.
- Storage:
  - One head register plus a (DEPTH-1)-entry FIFO.
  - count = FIFO occupancy + head_valid.
- Comparison:
  - diff = master_time - head_time, 32-bit modular arithmetic.
  - due = ~diff[31], i.e. diff ≥ 0 as signed.
  - late = due & (diff > LATE_THRESH).
  - Entries more than 2^31-1 ticks away are interpreted as past; the producer's responsibility.
- FSM:
  - IDLE: no head.
    - On push, or when the FIFO is non-empty, load the head, then go to ARMED.
    - A write in IDLE lands in the head on the cycle after acceptance (1-cycle latency).
  - ARMED: evaluate due every cycle.
    - If due & ~late: the next cycle has trig_o=1 and trig_tag = head tag. Go to POP.
    - If late: the next cycle has late_o=1 and trig_tag = head tag. Go to POP.
  - POP: free the head.
    - If the FIFO is non-empty, reload the head in the same cycle, then go to ARMED.
    - Otherwise go to IDLE.
  - Throughput: one fire per 2 cycles maximum. Back-to-back entries with equal times fire on consecutive alternate cycles, in order.
- Ordering:
  - Strict FIFO order, not sorted.
  - A later entry with an earlier time fires only after its predecessor: late if past threshold, immediate if within.
- Simultaneous push and pop while full: push refused (wr_ready=0 that cycle); pop proceeds.
- clear:
  - Next cycle count=0 and FSM in IDLE.
  - No trig_o/late_o for flushed entries.
  - A strobe already registered that cycle still appears.
  - A push concurrent with clear is dropped; wr_ready is still 1.
- master_time step (e.g. resync to 0): the head becomes "future" by the signed rule and waits; no spurious fire.
- Outputs trig_o, late_o and trig_tag are registered.

Optional Feature:
- TIME_TRIG_LATE_DETECT_EN defined: late detection exactly as above.
- Not defined:
  - late_o is tied to 0 and LATE_THRESH is ignored.
  - Every due entry fires via trig_o regardless of how far past its time it is.

Decomposition:
- Package time_trig_pkg holds:
  - FSM state enum (IDLE, ARMED, POP).
  - TIME_W=32 constant.
  - Function time_due(now, t) returning the signed-diff due flag.
- One sub-module: trig_fifo.
  - Synchronous FIFO storing {time, tag}, width 32+TAG_W, depth DEPTH-1.
  - Async active-low reset; push/pop/flush ports; full/empty/level outputs.

Test Plan:
- Push {time=100, tag=0x5A} at master_time=90 → trig_o=1, trig_tag=0x5A exactly one cycle after master_time=100 is sampled; no other strobes.
- Push {time=50, tag=0x11} at master_time=2000, TIME_TRIG_LATE_DETECT_EN defined → late_o=1, trig_tag=0x11, trig_o=0. Same stimulus with the macro undefined → trig_o=1.
- Push 8 entries with time 0x200 while master_time=0x100 → count=8 and wr_ready=0; 9th push refused. At 0x200, eight trig_o pulses in tag order on alternate cycles; count returns to 0.
- Wrap: push time=0x00000010 at master_time=0xFFFFFFF0 → no fire before wrap; fire one cycle after master_time=0x10.
- Resync: head time=5000, master_time jumps from 4000 to 0 → no fire until master_time=5000.
- clear with 3 entries pending and rst_n pulsed low mid-ARMED → no strobes; count=0 asynchronously on reset; queue accepts pushes again after rst_n rises.
